shift_add_mult_ctrl: RTL and testbench

- Multi-cycle unsigned 32x32 -> 64-bit multiplier controller for the datapath.
- Sequences one instance of the existing 32-bit ripple adder (adder_thirtyTwo) once per cycle, using the classic shift-add algorithm.
- Lets the datapath execute MULT-class instructions through a start/done handshake without adding a combinational multiplier array.

---
 rtl/mult_pkg.sv | 14 +
 rtl/adder_thirtyTwo.sv | 24 ++
 rtl/shift_add_mult_ctrl.sv | 97 +++++++++
 tb/tb_shift_add_mult_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared encodings and sizing for the shift-add multiplier controller.
// Pure declarations: no latency and no handshake live here.
package mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam int ITER  = 32;
  localparam int CNT_W = 5;

endpackage

// File: rtl/adder_thirtyTwo.sv
// 32-bit ripple-carry adder with carry in/out. Purely combinational.
// Zero latency, no flow control.
module adder_thirtyTwo (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < 32; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[32];
  end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Unsigned 32x32->64 shift-add multiplier: 33 cycles start-to-done (1 with zero bypass).
// start is only honoured in IDLE/DONE; requests during RUN are dropped, not queued.
module shift_add_mult_ctrl
  import mult_pkg::*;
#(
  parameter bit ZERO_BYPASS = 1'b1,
  parameter int ITER        = mult_pkg::ITER
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] product_hi,
  output logic [31:0] product_lo,
  output logic        ovf
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        m_q, m_d;
  logic [64:0]        p_q, p_d;
  logic               ovf_q;

  logic [31:0]        add_sum;
  logic               add_cout;
  logic [32:0]        acc;

  adder_thirtyTwo u_adder (
    .a    (p_q[63:32]),
    .b    (m_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    m_d     = m_q;
    p_d     = p_q;
    acc     = {1'b0, p_q[63:32]};

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          m_d     = multiplicand;
          p_d     = {33'b0, multiplier};
          count_d = '0;
          state_d = S_RUN;
          if (ZERO_BYPASS && ((multiplicand == '0) || (multiplier == '0))) begin
            p_d     = '0;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        // Carry is kept as bit 64 before the shift so the top product bit survives.
        if (p_q[0]) begin
          acc = {add_cout, add_sum};
        end
        p_d     = {1'b0, acc, p_q[31:1]};
        count_d = count_q + 1'b1;
        if (count_q == CNT_W'(ITER - 1)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      m_q     <= '0;
      p_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      m_q     <= m_d;
      p_q     <= p_d;
      ovf_q   <= (p_d[63:32] != '0);
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign product_hi = p_q[63:32];
  assign product_lo = p_q[31:0];
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl; u_dut0 has zero bypass, u_dut1 does not.
module tb_shift_add_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] mcand, mplier;
  logic        busy0, done0, ovf0, busy1, done1, ovf1;
  logic [31:0] hi0, lo0, hi1, lo1;

  int vectors = 0;
  int errs    = 0;
  int n, nb, n2, nb2, ndone;

  always #5 clk = ~clk;

  shift_add_mult_ctrl #(.ZERO_BYPASS(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .multiplicand(mcand), .multiplier(mplier),
    .busy(busy0), .done(done0), .product_hi(hi0), .product_lo(lo0), .ovf(ovf0)
  );

  shift_add_mult_ctrl #(.ZERO_BYPASS(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .multiplicand(mcand), .multiplier(mplier),
    .busy(busy1), .done(done1), .product_hi(hi1), .product_lo(lo1), .ovf(ovf1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps negedges until the selected DUT shows done; n = negedges since accept edge.
  task automatic wait_done(input int sel, input int max, output int cyc, output int nbusy);
    logic seen;
    cyc   = 0;
    nbusy = 0;
    seen  = 1'b0;
    while (!seen && cyc < max) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (sel == 0 ? busy0 : busy1) nbusy++;
      seen = (sel == 0) ? done0 : done1;
    end
    if (!seen) cyc = max + 1;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input logic exp_ovf);
    int c, bc;
    start = 1'b1;
    mcand = a;
    mplier = b;
    wait_done(0, 40, c, bc);
    chk({tag, "_latency"}, c, 33);
    chk({tag, "_busy_cycles"}, bc, 32);
    chk({tag, "_product"}, {hi0, lo0}, exp);
    chk({tag, "_ovf"}, ovf0, exp_ovf);
    chk({tag, "_product_nobypass"}, {hi1, lo1}, exp);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done0, 1'b0);
    chk({tag, "_product_hold"}, {hi0, lo0}, exp);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b1;
    mcand  = 32'hFFFF_FFFF;
    mplier = 32'hFFFF_FFFF;

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_busy", busy0, 1'b0);
      chk("reset_done", done0, 1'b0);
      chk("reset_product", {hi0, lo0}, 64'h0);
      chk("reset_ovf", ovf0, 1'b0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("post_reset_idle_busy", busy0, 1'b0);
    chk("post_reset_idle_done", done0, 1'b0);

    run_op("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0);
    run_op("max_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    run_op("8000x2", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 1'b1);

    // Zero operand: bypass instance finishes after edge 0, the other after edge 32.
    start = 1'b1;
    mcand = 32'h0;
    mplier = 32'h1234_ABCD;
    wait_done(0, 40, n, nb);
    chk("zero_bypass_latency", n, 1);
    chk("zero_bypass_busy", nb, 0);
    chk("zero_bypass_product", {hi0, lo0}, 64'h0);
    wait_done(1, 40, n2, nb2);
    chk("zero_full_latency", n + n2, 33);
    chk("zero_full_product", {hi1, lo1}, 64'h0);
    @(negedge clk);
    chk("zero_full_done_drop", done1, 1'b0);

    start = 1'b1;
    mcand = 32'hABCD;
    mplier = 32'h0;
    wait_done(0, 40, n, nb);
    chk("zero_b_bypass_latency", n, 1);
    wait_done(1, 40, n2, nb2);
    @(negedge clk);

    // Mid-run start with new operands must be ignored.
    start = 1'b1;
    mcand = 32'd7;
    mplier = 32'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b1;
    mcand = 32'h0000_1111;
    mplier = 32'h0000_2222;
    @(negedge clk);
    start = 1'b0;
    mcand = 32'hDEAD_0000;
    mplier = 32'h0000_BEEF;
    wait_done(0, 40, n, nb);
    chk("midrun_latency", n, 22);
    chk("midrun_product", {hi0, lo0}, 64'h0000_0000_0000_003F);
    ndone = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    chk("midrun_single_done", ndone, 0);

    // Back-to-back: start held through the DONE cycle is accepted directly into RUN.
    start = 1'b1;
    mcand = 32'd2;
    mplier = 32'd3;
    wait_done(0, 40, n, nb);
    chk("b2b_first_product", {hi0, lo0}, 64'd6);
    start = 1'b1;
    mcand = 32'd4;
    mplier = 32'd5;
    @(negedge clk);
    chk("b2b_busy_after_done", busy0, 1'b1);
    chk("b2b_no_second_done", done0, 1'b0);
    wait_done(0, 40, n, nb);
    chk("b2b_second_latency", n + 1, 33);
    chk("b2b_second_product", {hi0, lo0}, 64'h14);
    @(negedge clk);

    // Reset in the middle of an operation.
    start = 1'b1;
    mcand = 32'hDEAD_BEEF;
    mplier = 32'h1234_5678;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_abort_busy", busy0, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", busy0, 1'b0);
    chk("abort_done", done0, 1'b0);
    chk("abort_product", {hi0, lo0}, 64'h0);
    chk("abort_ovf", ovf0, 1'b0);
    ndone = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (done0 || busy0) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_op("6x7", 32'd6, 32'd7, 64'h2A, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
